input_conditioner: RTL

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/input_conditioner.sv | 89 ++++++++
 1 files changed

// File: rtl/input_conditioner.sv
// Button synchronizer, per-bit debouncer, press detector and game tick.
// Ports: clk, rst (async high), btn_raw[3:0] -> btn_level, btn_press,
//   game_tick, tick_press. Bit order {up,down,left,right}.
module input_conditioner #(
  parameter int DB_COUNT = 500000,
  parameter int TICK_DIV = 2500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_raw,
  output logic [3:0] btn_level,
  output logic [3:0] btn_press,
  output logic       game_tick,
  output logic [3:0] tick_press
);

  localparam int DBW = $clog2(DB_COUNT);
  localparam int TW  = $clog2(TICK_DIV);
  localparam logic [DBW-1:0] DB_MAX = DBW'(DB_COUNT - 1);
  localparam logic [TW-1:0]  TK_MAX = TW'(TICK_DIV - 1);

  logic [3:0]     s1;
  logic [3:0]     s2;
  logic [DBW-1:0] db_cnt [4];
  logic [TW-1:0]  tick_cnt;
  logic [3:0]     pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  // Level flips on the DB_COUNT-th consecutive differing sample;
  // any agreeing sample restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_level <= '0;
      btn_press <= '0;
      for (int i = 0; i < 4; i++)
        db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        btn_press[i] <= 1'b0;
        if (s2[i] == btn_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          btn_level[i] <= s2[i];
          btn_press[i] <= s2[i];
          db_cnt[i]    <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt  <= '0;
      game_tick <= 1'b0;
    end else begin
      game_tick <= (tick_cnt == TK_MAX);
      if (tick_cnt == TK_MAX)
        tick_cnt <= '0;
      else
        tick_cnt <= tick_cnt + TW'(1);
    end
  end

  // A press landing on the tick cycle goes straight into tick_press
  // and is not kept pending for the next period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending    <= '0;
      tick_press <= '0;
    end else if (game_tick) begin
      tick_press <= pending | btn_press;
      pending    <= '0;
    end else begin
      pending <= pending | btn_press;
    end
  end

endmodule
